// File: rtl/unified_mem_ctrl.sv
// Unified fetch/load-store controller onto one single-port word memory with RV32I lane handling.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module unified_mem_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter bit          DATA_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              stall,
    output logic              mem_en,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StData
    } state_e;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord
    } size_e;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        we_q, we_d;
    logic        mis_q, mis_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q, d_done_d;

    logic        if_pend, d_pend, grant_d, grant_if;
    logic        if_done, d_done;
    logic        mis_now;
    size_e       st_size, ld_size;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic        ld_uns;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Fetch addresses are word-aligned; the low bits carry no information.
    logic unused_if_lo;
    assign unused_if_lo = ^if_addr[1:0];

    // Reserved encodings fall through to word accesses.
    function automatic size_e size_of(input logic [2:0] f3);
        unique case (f3)
            3'b000, 3'b100: size_of = SzByte;
            3'b001, 3'b101: size_of = SzHalf;
            default:        size_of = SzWord;
        endcase
    endfunction

    always_comb begin
        st_size  = size_of(d_funct3);
        st_be    = 4'b0000;
        st_wdata = d_wdata;
        unique case (st_size)
            SzByte: begin
                st_be    = 4'b0001 << d_addr[1:0];
                st_wdata = {4{d_wdata[7:0]}};
            end
            SzHalf: begin
                st_be    = 4'b0011 << {d_addr[1], 1'b0};
                st_wdata = {2{d_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = d_wdata;
            end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_now = ((st_size == SzHalf) && d_addr[0])
                  || ((st_size == SzWord) && (d_addr[1:0] != 2'b00));
`else
    assign mis_now = 1'b0;
`endif

    always_comb begin
        ld_size = size_of(funct3_q);
        ld_uns  = funct3_q[2];
        ld_byte = 8'h00;
        unique case (addr_lo_q)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = mem_rdata;
        unique case (ld_size)
            SzByte:  ld_data = ld_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SzHalf:  ld_data = ld_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        we_d      = we_q;
        mis_d     = mis_q;
        if_rdata  = 32'h0;
        if_valid  = 1'b0;
        d_rdata   = 32'h0;
        d_valid   = 1'b0;
        mem_en    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign  = 1'b0;
`endif
        if_pend   = if_req & ~if_done_q;
        d_pend    = d_req & ~d_done_q;
        grant_d   = d_pend & (DATA_PRIO | ~if_pend);
        grant_if  = if_pend & ~grant_d;

        // Every output and the memory strobe are forced quiet while reset is sampled.
        if (!rst) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_d) begin
                        mem_en    = 1'b1;
                        mem_addr  = d_addr[ADDR_W-1:2];
                        if (d_we && !mis_now) begin
                            mem_be    = st_be;
                            mem_wdata = st_wdata;
                        end
                        funct3_d  = d_funct3;
                        addr_lo_d = d_addr[1:0];
                        we_d      = d_we;
                        mis_d     = mis_now;
                        state_d   = StData;
                    end else if (grant_if) begin
                        mem_en   = 1'b1;
                        mem_addr = if_addr[ADDR_W-1:2];
                        state_d  = StFetch;
                    end
                end
                StFetch: begin
                    if_valid = 1'b1;
                    if_rdata = mem_rdata;
                    state_d  = StIdle;
                end
                StData: begin
                    d_valid = 1'b1;
                    if (!we_q && !mis_q) begin
                        d_rdata = ld_data;
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    misalign = mis_q;
`endif
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // A completed requester stays marked done until the core advances or drops the request.
    always_comb begin
        if_done   = if_done_q | if_valid;
        d_done    = d_done_q | d_valid;
        stall     = rst & ((if_req & ~if_done) | (d_req & ~d_done));
        if_done_d = if_done & if_req & stall;
        d_done_d  = d_done & d_req & stall;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
            we_q      <= 1'b0;
            mis_q     <= 1'b0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            we_q      <= we_d;
            mis_q     <= mis_d;
            if_done_q <= if_done_d;
            d_done_q  <= d_done_d;
        end
    end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: directed vector table, hand sequences, and random traffic
// checked against a byte-addressed reference memory.
module tb_unified_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        stall;
    logic        mem_en;
    logic [3:0]  mem_be;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_err    = 0;

    unified_mem_ctrl #(
        .ADDR_W   (8),
        .DATA_PRIO(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_funct3 (d_funct3),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .stall    (stall),
        .mem_en   (mem_en),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign (misalign),
`endif
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous word memory; preload/clear ports let the bench seed it without a second driver.
    logic [31:0] tb_mem [64];
    logic        mem_clr;
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= 32'h0;
        end else if (pre_we) begin
            tb_mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) tb_mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
            mem_rdata <= tb_mem[mem_addr];
        end
    end

    // Reference model: a flat byte array, little-endian.
    logic [7:0] ref_b [256];

    function automatic int nbytes(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [7:0] a);
        int nb;
        nb = nbytes(f3);
        return (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [7:0] a);
        int          nb;
        int          base;
        logic [31:0] v;
        nb   = nbytes(f3);
        base = int'(a) & ~(nb - 1);
        v    = 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (ref_misaligned(f3, a)) return 32'h0;
`endif
        for (int i = 0; i < nb; i++) v = v | (32'(ref_b[8'(base + i)]) << (8 * i));
        if (nb < 4 && !f3[2] && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] ref_fetch(input logic [7:0] a);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < 4; i++) v = v | (32'(ref_b[8'((int'(a) & ~3) + i)]) << (8 * i));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd,
                             output logic [3:0] be, output logic [31:0] mwd);
        int nb;
        int base;
        nb   = nbytes(f3);
        base = int'(a) & ~(nb - 1);
        be   = 4'(((1 << nb) - 1) << (base % 4));
        mwd  = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
`ifdef MEM_MISALIGN_TRAP_EN
        if (ref_misaligned(f3, a)) begin
            be  = 4'h0;
            mwd = 32'h0;
            return;
        end
`endif
        for (int i = 0; i < nb; i++) ref_b[8'(base + i)] = wd[8*i +: 8];
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] w);
        pre_we   = 1'b1;
        pre_addr = a[7:2];
        pre_data = w;
        for (int i = 0; i < 4; i++) ref_b[8'((int'(a) & ~3) + i)] = w[8*i +: 8];
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          d_cyc;
        int          i_cyc;
        int          drop_cyc;
        int          en_cnt;
        logic [31:0] drd;
        logic [31:0] ird;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic        mis;
    } cap_t;

    // Called just after a rising edge; holds requests until stall drops, then releases them.
    task automatic txn(input logic do_i, input logic [7:0] ia, input logic do_d, input logic we,
                       input logic [2:0] f3, input logic [7:0] da, input logic [31:0] wd,
                       output cap_t c);
        c.d_cyc = -1; c.i_cyc = -1; c.drop_cyc = -1; c.en_cnt = 0;
        c.drd = 32'h0; c.ird = 32'h0; c.be = 4'h0; c.mwd = 32'h0; c.mis = 1'b0;
        if_req = do_i; if_addr = ia;
        d_req = do_d; d_we = we; d_funct3 = f3; d_addr = da; d_wdata = wd;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (mem_en) begin
                c.en_cnt++;
                if (mem_be != 4'h0) begin
                    c.be  = mem_be;
                    c.mwd = mem_wdata;
                end
            end
            if (d_valid) begin
                c.d_cyc = k;
                c.drd   = d_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
                c.mis   = misalign;
`endif
            end
            if (if_valid) begin
                c.i_cyc = k;
                c.ird   = if_rdata;
            end
            if (!stall) begin
                c.drop_cyc = k;
                break;
            end
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] mwd;
    } vec_t;

    vec_t        vt [15];
    cap_t        c;
    logic [3:0]  ebe;
    logic [31:0] emwd;
    logic [31:0] exp_d;
    logic [31:0] exp_i;

    initial begin
        vt[0]  = '{1'b0, 3'b000, 8'h13, 32'h0,        32'hFFFFFF80, 4'h0, 32'h0};
        vt[1]  = '{1'b0, 3'b100, 8'h13, 32'h0,        32'h00000080, 4'h0, 32'h0};
        vt[2]  = '{1'b0, 3'b001, 8'h12, 32'h0,        32'hFFFF80FF, 4'h0, 32'h0};
        vt[3]  = '{1'b0, 3'b101, 8'h12, 32'h0,        32'h000080FF, 4'h0, 32'h0};
        vt[4]  = '{1'b0, 3'b000, 8'h11, 32'h0,        32'h0000007F, 4'h0, 32'h0};
        vt[5]  = '{1'b0, 3'b010, 8'h10, 32'h0,        32'h80FF7F01, 4'h0, 32'h0};
        vt[6]  = '{1'b1, 3'b000, 8'h21, 32'h123456AB, 32'h0,        4'b0010, 32'hABABABAB};
        vt[7]  = '{1'b0, 3'b010, 8'h20, 32'h0,        32'h0000AB00, 4'h0, 32'h0};
        vt[8]  = '{1'b1, 3'b001, 8'h22, 32'hFFFF1234, 32'h0,        4'b1100, 32'h12341234};
        vt[9]  = '{1'b0, 3'b010, 8'h20, 32'h0,        32'h1234AB00, 4'h0, 32'h0};
        vt[10] = '{1'b1, 3'b010, 8'h24, 32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF};
        vt[11] = '{1'b0, 3'b011, 8'h24, 32'h0,        32'hDEADBEEF, 4'h0, 32'h0};
`ifdef MEM_MISALIGN_TRAP_EN
        vt[12] = '{1'b0, 3'b001, 8'h21, 32'h0,        32'h00000000, 4'h0, 32'h0};
`else
        vt[12] = '{1'b0, 3'b001, 8'h21, 32'h0,        32'hFFFFAB00, 4'h0, 32'h0};
`endif
        vt[13] = '{1'b0, 3'b101, 8'h26, 32'h0,        32'h0000DEAD, 4'h0, 32'h0};
        vt[14] = '{1'b0, 3'b010, 8'h40, 32'h0,        32'h00000000, 4'h0, 32'h0};

        for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;
        pre_we = 1'b0; pre_addr = 6'h0; pre_data = 32'h0;
        // Requests, including a store, are held active throughout reset.
        rst = 1'b0; mem_clr = 1'b1;
        if_req = 1'b1; if_addr = 8'h08;
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 8'h40; d_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        mem_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", 32'({if_valid, d_valid, stall, mem_en, mem_be}), 32'h0);
        check("reset_if_rdata", if_rdata, 32'h0);
        check("reset_d_rdata", d_rdata, 32'h0);
        check("reset_mem_addr", 32'(mem_addr), 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("reset_misalign", 32'(misalign), 32'h0);
`endif
        @(posedge clk);
        #1;
        preload(8'h08, 32'h00500093);
        preload(8'h10, 32'h80FF7F01);
        preload(8'h30, 32'hCAFEF00D);
        if_req = 1'b0; d_req = 1'b0; rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            txn(1'b0, 8'h00, 1'b1, vt[i].we, vt[i].f3, vt[i].a, vt[i].wd, c);
            if (vt[i].we) ref_store(vt[i].f3, vt[i].a, vt[i].wd, ebe, emwd);
            check($sformatf("tbl%0d_rdata", i), c.drd, vt[i].rd);
            check($sformatf("tbl%0d_be", i), 32'(c.be), 32'(vt[i].be));
            check($sformatf("tbl%0d_wdata", i), c.mwd, vt[i].mwd);
            check($sformatf("tbl%0d_dcyc", i), c.d_cyc, 1);
        end

        txn(1'b1, 8'h08, 1'b0, 1'b0, 3'b010, 8'h00, 32'h0, c);
        check("fetch_rdata", c.ird, 32'h00500093);
        check("fetch_icyc", c.i_cyc, 1);
        check("fetch_stall_drop", c.drop_cyc, 1);

        txn(1'b1, 8'h08, 1'b1, 1'b0, 3'b010, 8'h30, 32'h0, c);
        check("cont_drdata", c.drd, 32'hCAFEF00D);
        check("cont_dcyc", c.d_cyc, 1);
        check("cont_ird", c.ird, 32'h00500093);
        check("cont_icyc", c.i_cyc, 3);
        check("cont_stall_drop", c.drop_cyc, 3);
        check("cont_mem_en_cnt", c.en_cnt, 2);

        // Reset asserted in the response cycle of a load; the held request must re-issue.
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 8'h30;
        @(negedge clk);
        check("rstmid_issue", 32'(mem_en), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_ctl", 32'({if_valid, d_valid, stall, mem_en, mem_be}), 32'h0);
        check("rstmid_d_rdata", d_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        txn(1'b0, 8'h00, 1'b1, 1'b0, 3'b010, 8'h30, 32'h0, c);
        check("rstmid_reissue_cnt", c.en_cnt, 1);
        check("rstmid_reissue_dcyc", c.d_cyc, 1);
        check("rstmid_reissue_rdata", c.drd, 32'hCAFEF00D);

`ifdef MEM_MISALIGN_TRAP_EN
        txn(1'b0, 8'h00, 1'b1, 1'b1, 3'b010, 8'h05, 32'h11223344, c);
        ref_store(3'b010, 8'h05, 32'h11223344, ebe, emwd);
        check("mis_be", 32'(c.be), 32'h0);
        check("mis_flag", 32'(c.mis), 32'h1);
        check("mis_dcyc", c.d_cyc, 1);
        check("mis_rdata", c.drd, 32'h0);
        txn(1'b0, 8'h00, 1'b1, 1'b0, 3'b010, 8'h04, 32'h0, c);
        check("mis_mem_unchanged", c.drd, ref_load(3'b010, 8'h04));
`endif

        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic        r_we;
            logic [2:0]  r_f3;
            logic [7:0]  r_da;
            logic [7:0]  r_ia;
            logic [31:0] r_wd;
            logic        do_i;
            logic        do_d;
            kind = $urandom_range(0, 2);
            do_i = (kind != 1);
            do_d = (kind != 0);
            r_we = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            r_da = 8'($urandom_range(0, 255));
            r_ia = 8'(4 * $urandom_range(0, 63));
            r_wd = $urandom;
            ebe  = 4'h0;
            emwd = 32'h0;
            exp_d = 32'h0;
            if (do_d) begin
                if (r_we) ref_store(r_f3, r_da, r_wd, ebe, emwd);
                else exp_d = ref_load(r_f3, r_da);
            end
            exp_i = ref_fetch(r_ia);
            txn(do_i, r_ia, do_d, r_we, r_f3, r_da, r_wd, c);
            check($sformatf("rnd%0d_en_cnt", n), c.en_cnt, (do_i && do_d) ? 2 : 1);
            check($sformatf("rnd%0d_stall_drop", n), c.drop_cyc, (do_i && do_d) ? 3 : 1);
            if (do_d) begin
                check($sformatf("rnd%0d_dcyc", n), c.d_cyc, 1);
                check($sformatf("rnd%0d_drdata", n), c.drd, exp_d);
                check($sformatf("rnd%0d_be", n), 32'(c.be), 32'(ebe));
                check($sformatf("rnd%0d_wdata", n), c.mwd, emwd);
`ifdef MEM_MISALIGN_TRAP_EN
                check($sformatf("rnd%0d_mis", n), 32'(c.mis), 32'(ref_misaligned(r_f3, r_da)));
`endif
            end
            if (do_i) begin
                check($sformatf("rnd%0d_icyc", n), c.i_cyc, do_d ? 3 : 1);
                check($sformatf("rnd%0d_ird", n), c.ird, exp_i);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/unified_mem_ctrl.md
Name: unified_mem_ctrl

Overview:
- Single-port memory controller that sits directly downstream of the CPU core's fetch and load/store paths.
- Arbitrates instruction-fetch and data requests onto one synchronous word-wide memory.
- Performs RV32I byte/halfword lane steering on stores and sign/zero extension on loads, per funct3.
- Drives a stall to the core while an access is outstanding; the core holds PC and request inputs while stall=1.

Parameters:
- ADDR_W, 8, byte-address width; memory depth = 2^(ADDR_W-2) words.
- DATA_PRIO, 1, 1 = data request beats fetch when both are pending; 0 = fetch first.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch byte address, word-aligned
- if_rdata  out  32  fetched instruction
- if_valid  out  1  one-cycle pulse; if_rdata is valid this cycle
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data, right-aligned
- d_rdata  out  32  extended load result
- d_valid  out  1  one-cycle pulse; the load/store has completed
- stall  out  1  core must hold state
- mem_en  out  1  memory access strobe
- mem_be  out  4  byte write enables; 0000 = read
- mem_addr  out  ADDR_W-2  word index
- mem_wdata  out  32  lane-steered store data
- mem_rdata  in  32  memory read data, valid one cycle after mem_en

Behaviour:
- FSM states:
  - IDLE: no access in flight.
  - FETCH: read issued last cycle, awaiting data.
  - DATA: load/store issued last cycle, awaiting completion.
- IDLE transitions:
  - Select a winner by DATA_PRIO among pending requests.
  - Drive mem_en=1 and mem_addr = addr[ADDR_W-1:2] combinationally.
  - Drive mem_be for stores; mem_be=0000 for reads.
  - Register the winner's funct3 and addr[1:0], then go to FETCH or DATA.
  - No request pending: stay in IDLE, mem_en=0.
- FETCH: if_rdata = mem_rdata, if_valid=1, return to IDLE.
- DATA, load:
  - Select byte lane = addr[1:0] or halfword lane = addr[1].
  - Sign-extend for B/H; zero-extend for BU/HU; W passes through.
  - Assert d_valid=1 and drive d_rdata, then return to IDLE.
- DATA, store:
  - The write commits at the issue edge.
  - d_valid=1 in DATA; d_rdata=0.
- Store lane steering:
  - SB: mem_be = 0001 << addr[1:0]; wdata byte replicated ×4.
  - SH: mem_be = 0011 << (2·addr[1]); wdata halfword replicated ×2.
  - SW: mem_be = 1111.
- Latency and throughput:
  - Each access takes 2 cycles, issue plus response. No back-to-back overlap.
  - Minimum gap between completions is 2 cycles.
- stall:
  - stall = (if_req | d_req) & ~(completion of this requester's access in the current cycle).
  - Equivalently, stall drops only in a cycle where every asserted request has received its valid pulse.
  - A request granted earlier holds a completion flag, cleared when the core deasserts the request or advances, so it is not re-issued.
- Simultaneous if_req and d_req (DATA_PRIO=1):
  - Data is served first (cycles 0–1), then the fetch (cycles 2–3).
  - stall=1 for cycles 0–2; stall=0 in cycle 3.
- Reserved d_funct3 (011, 110, 111): treated as W.
- Reset (rst=0 on any edge, including mid-access):
  - FSM goes to IDLE and completion flags clear.
  - if_valid, d_valid, mem_en, stall = 0; mem_be = 0000; if_rdata, d_rdata, mem_addr, mem_wdata = 0.
  - An in-flight response is discarded.
  - A store issued on the same edge that reset is sampled is suppressed: mem_be is gated by rst.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- When defined:
  - Adds output port misalign (1 bit).
  - Misaligned cases: H/HU with addr[0]=1; W with addr[1:0]≠00.
  - A misaligned data access issues no memory write (mem_be=0000).
  - It still completes in 2 cycles: d_valid=1, d_rdata=0, misalign=1 for that cycle.
  - misalign resets to 0.
- When undefined:
  - No port.
  - Misaligned addresses are truncated: H uses addr[1] only, W ignores addr[1:0].

Test Plan:
- Fetch only: if_req=1, if_addr=0x08, mem word 2 = 0x00500093 → if_valid in cycle 1 with if_rdata=0x00500093; stall=1 in cycle 0 only.
- Load sign extension: word 0x10 = 0x80FF7F01, LB at 0x13 → d_rdata=0xFFFFFF80; LBU at 0x13 → 0x00000080; LH at 0x12 → 0xFFFF80FF; LHU → 0x000080FF.
- Store lanes: SB 0xAB at 0x21 → mem_be=0010, mem_wdata=0xABABABAB; readback LW 0x20 over an initial 0 → 0x0000AB00. SH 0x1234 at 0x22 → mem_be=1100.
- Contention: if_req and d_req (LW 0x30) asserted together, DATA_PRIO=1 → d_valid cycle 1, if_valid cycle 3, stall high cycles 0–2, exactly two mem_en pulses.
- Reset mid-access: rst=0 in the cycle after an LW issue → no d_valid, FSM in IDLE, all outputs 0; after rst=1, the held request re-issues and completes.
- MEM_MISALIGN_TRAP_EN defined: SW at 0x05 → mem_be=0000, misalign=1 and d_valid=1 in cycle 1, memory unchanged.
